// File: rtl/wram_dma.sv
// CPU work RAM with address mirroring and a page-DMA read engine.
// The CPU is stalled (cpu_rdy=0) for the whole of a page transfer.
module wram_dma #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int CPU_ADDR_WIDTH = 13,
  parameter int PAGE_BITS      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_en,
  input  logic                            cpu_r_nw,
  input  logic [CPU_ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]           cpu_din,
  output logic [DATA_WIDTH-1:0]           cpu_dout,
  output logic                            cpu_rdy,
  input  logic                            dma_start,
  input  logic [ADDR_WIDTH-PAGE_BITS-1:0] dma_page,
  output logic                            dma_valid,
  input  logic                            dma_ready,
  output logic [DATA_WIDTH-1:0]           dma_data,
  output logic [PAGE_BITS-1:0]            dma_idx,
  output logic                            dma_busy,
  output logic                            dma_done
);

  localparam int PW    = ADDR_WIDTH - PAGE_BITS;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // state | meaning
  // IDLE  | CPU owns the RAM, waiting for dma_start
  // FETCH | RAM read of {page, idx} issued
  // WAIT  | word presented on dma_data/dma_idx until accepted
  // DONE  | one-cycle dma_done pulse
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          page_q, page_d;
  logic [PAGE_BITS-1:0]   idx_q, idx_d;
  logic                   cpu_rd_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   busy;
  logic                   cpu_wr;
  logic                   cpu_rd;
  logic                   dma_rd;
  logic [ADDR_WIDTH-1:0]  cpu_ram_addr;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   unused_addr_hi;

  assign busy           = (state_q != S_IDLE);
  assign cpu_ram_addr   = cpu_addr[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^cpu_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH];
  assign cpu_wr         = ~busy & cpu_en & ~cpu_r_nw;
  assign cpu_rd         = ~busy & cpu_en & cpu_r_nw;
  assign dma_rd         = (state_q == S_FETCH);
  assign rd_addr        = dma_rd ? {page_q, idx_q} : cpu_ram_addr;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          page_d  = dma_page;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (dma_ready) begin
          if (idx_q == {PAGE_BITS{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + {{(PAGE_BITS-1){1'b0}}, 1'b1};
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      cpu_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      cpu_rd_q <= cpu_rd;
    end
  end

  // RAM contents survive reset; a single read port is shared since CPU and DMA never overlap.
  always_ff @(posedge clk) begin
    if (cpu_wr) mem_q[cpu_ram_addr] <= cpu_din;
    if (cpu_rd | dma_rd) rd_data_q <= mem_q[rd_addr];
  end

  assign cpu_rdy   = ~busy;
  assign cpu_dout  = cpu_rd_q ? rd_data_q : '0;
  assign dma_valid = (state_q == S_WAIT);
  assign dma_data  = dma_valid ? rd_data_q : '0;
  assign dma_idx   = idx_q;
  assign dma_busy  = busy;
  assign dma_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_wram_dma.sv
// Randomized bench for wram_dma: transaction-level model of RAM + page stream,
// checked every cycle, plus literal expectations for the headline scenarios.
module tb_wram_dma;
  localparam int PAGE = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en = 1'b0;
  logic        cpu_r_nw = 1'b1;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic        dma_start = 1'b0;
  logic [2:0]  dma_page = '0;
  logic        dma_valid;
  logic        dma_ready = 1'b0;
  logic [7:0]  dma_data;
  logic [7:0]  dma_idx;
  logic        dma_busy;
  logic        dma_done;

  always #5 clk = ~clk;

  wram_dma dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .cpu_r_nw(cpu_r_nw),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
    .dma_start(dma_start), .dma_page(dma_page), .dma_valid(dma_valid),
    .dma_ready(dma_ready), .dma_data(dma_data), .dma_idx(dma_idx),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: RAM as an array, DMA as "which word of which page is on offer".
  logic [7:0] mm [2048];
  logic       m_busy = 1'b0, m_show = 1'b0, m_done = 1'b0;
  int         m_idx = 0;
  logic [2:0] m_page = '0;
  logic [7:0] m_dout = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_show <= 1'b0; m_done <= 1'b0; m_idx <= 0; m_dout <= '0;
    end else begin
      m_dout <= (!m_busy && cpu_en && cpu_r_nw) ? mm[cpu_addr[10:0]] : 8'h00;
      if (!m_busy && cpu_en && !cpu_r_nw) mm[cpu_addr[10:0]] <= cpu_din;
      if (!m_busy) begin
        if (dma_start) begin
          m_busy <= 1'b1; m_page <= dma_page; m_idx <= 0; m_show <= 1'b0;
        end
      end else if (m_done) begin
        m_busy <= 1'b0; m_done <= 1'b0;
      end else if (!m_show) begin
        m_show <= 1'b1;
      end else if (dma_ready) begin
        m_show <= 1'b0;
        if (m_idx == PAGE - 1) m_done <= 1'b1;
        else m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cpu_rdy", 32'(cpu_rdy), 32'(!m_busy));
      chk("dma_busy", 32'(dma_busy), 32'(m_busy));
      chk("dma_valid", 32'(dma_valid), 32'(m_show));
      chk("dma_done", 32'(dma_done), 32'(m_done));
      chk("cpu_dout", 32'(cpu_dout), 32'(m_dout));
      if (m_show) begin
        chk("dma_data", 32'(dma_data), 32'(mm[{m_page, m_idx[7:0]}]));
        chk("dma_idx", 32'(dma_idx), 32'(m_idx[7:0]));
      end
    end
  end

  // Accepted-word log and done counter, only ever appended/incremented here.
  logic [7:0] acc_idx [$];
  logic [7:0] acc_data [$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && dma_valid && dma_ready) begin
      acc_idx.push_back(dma_idx);
      acc_data.push_back(dma_data);
    end
    if (rst_n && dma_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
    cpu_en = 1'b1; cpu_r_nw = 1'b0; cpu_addr = a; cpu_din = d;
    tick();
    cpu_en = 1'b0; cpu_r_nw = 1'b1;
  endtask

  task automatic cpu_rd(input logic [12:0] a);
    cpu_en = 1'b1; cpu_r_nw = 1'b1; cpu_addr = a;
    tick();
    cpu_en = 1'b0;
  endtask

  task automatic start_dma(input logic [2:0] pg);
    dma_page = pg; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
  endtask

  // Runs until dma_done is visible; n = busy cycles seen, counting this first one.
  // noisy: random ready, random CPU traffic and random extra dma_start pulses.
  task automatic wait_done(input bit noisy, output int n);
    n = 1;
    while (!dma_done && n < 6000) begin
      if (noisy) begin
        dma_ready = 1'($urandom);
        cpu_en    = 1'($urandom);
        cpu_r_nw  = 1'($urandom);
        cpu_addr  = 13'($urandom);
        cpu_din   = 8'($urandom);
        dma_start = ($urandom_range(0, 7) == 0);
        dma_page  = 3'($urandom);
      end
      tick();
      n++;
    end
    chk("dma_done_seen", 32'(dma_done), 32'd1);
    cpu_en = 1'b0; cpu_r_nw = 1'b1; dma_start = 1'b0; dma_ready = 1'b1;
  endtask

  task automatic check_stream(input string nm, input int base, input logic [2:0] pg);
    chk({nm, "_count"}, 32'(acc_idx.size() - base), 32'd256);
    for (int k = 0; k < PAGE && base + k < acc_idx.size(); k++) begin
      chk({nm, "_idx"}, 32'(acc_idx[base + k]), 32'(k));
      chk({nm, "_data"}, 32'(acc_data[base + k]), 32'(mm[{pg, 8'(k)}]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, d0;
    logic [2:0] pg;

    repeat (3) tick();
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
    chk("rst_dma_valid", 32'(dma_valid), 32'h0);
    chk("rst_dma_busy", 32'(dma_busy), 32'h0);
    chk("rst_dma_done", 32'(dma_done), 32'h0);
    chk("rst_dma_idx", 32'(dma_idx), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 2048; i++)
      cpu_wr(13'(i) | 13'($urandom_range(0, 3) << 11), 8'($urandom));
    cpu_wr(13'h0555, 8'h5A);

    cpu_wr(13'h0003, 8'hA5);
    cpu_rd(13'h1803);
    chk("mirror_read", 32'(cpu_dout), 32'hA5);
    cpu_en = 1'b0; cpu_r_nw = 1'b1; cpu_addr = 13'h1803;
    tick();
    chk("disabled_read", 32'(cpu_dout), 32'h00);

    // Full page at ready=1
    for (int i = 0; i < PAGE; i++) cpu_wr(13'h1200 | 13'(i), 8'(i) ^ 8'h3C);
    dma_ready = 1'b1;
    base = acc_idx.size();
    d0 = done_cnt;
    start_dma(3'd2);
    wait_done(1'b0, n);
    chk("full_len", 32'(n), 32'd513);
    tick();
    chk("full_busy_after", 32'(dma_busy), 32'h0);
    chk("full_done_count", 32'(done_cnt - d0), 32'd1);
    chk("full_count", 32'(acc_idx.size() - base), 32'd256);
    for (int k = 0; k < PAGE && base + k < acc_idx.size(); k++) begin
      chk("full_idx", 32'(acc_idx[base + k]), 32'(k));
      chk("full_data", 32'(acc_data[base + k]), 32'(8'(k) ^ 8'h3C));
    end

    // Back-pressure with random CPU traffic and stray starts
    for (int r = 0; r < 2; r++) begin
      pg = 3'($urandom);
      base = acc_idx.size();
      d0 = done_cnt;
      start_dma(pg);
      wait_done(1'b1, n);
      tick();
      tick();
      chk("bp_done_count", 32'(done_cnt - d0), 32'd1);
      check_stream("bp", base, pg);
    end

    // Collisions
    cpu_wr(13'h0011, 8'h11);
    base = acc_idx.size();
    d0 = done_cnt;
    cpu_en = 1'b1; cpu_r_nw = 1'b0; cpu_addr = 13'h0010; cpu_din = 8'h77;
    start_dma(3'd0);
    cpu_en = 1'b0; cpu_r_nw = 1'b1;
    repeat (4) tick();
    cpu_en = 1'b1; cpu_r_nw = 1'b0; cpu_addr = 13'h0011; cpu_din = 8'hEE;
    dma_page = 3'd1; dma_start = 1'b1;
    tick();
    cpu_en = 1'b0; cpu_r_nw = 1'b1; dma_start = 1'b0;
    wait_done(1'b0, n);
    repeat (3) tick();
    chk("coll_busy_after", 32'(dma_busy), 32'h0);
    chk("coll_done_count", 32'(done_cnt - d0), 32'd1);
    chk("coll_count", 32'(acc_idx.size() - base), 32'd256);
    if (acc_idx.size() > base + 16)
      chk("coll_stream_word10", 32'(acc_data[base + 16]), 32'h77);
    cpu_rd(13'h0010);
    chk("coll_start_write", 32'(cpu_dout), 32'h77);
    cpu_rd(13'h0811);
    chk("coll_busy_write", 32'(cpu_dout), 32'h11);

    // Abort after 100 words
    base = acc_idx.size();
    d0 = done_cnt;
    start_dma(3'd3);
    n = 0;
    while (acc_idx.size() - base < 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reached_100", 32'(acc_idx.size() - base >= 100), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(dma_busy), 32'h0);
    chk("abort_rdy", 32'(cpu_rdy), 32'h1);
    chk("abort_valid", 32'(dma_valid), 32'h0);
    chk("abort_done", 32'(dma_done), 32'h0);
    chk("abort_dout", 32'(cpu_dout), 32'h0);
    chk("abort_data", 32'(dma_data), 32'h0);
    chk("abort_idx", 32'(dma_idx), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    cpu_rd(13'h1D55);
    chk("ram_kept_5a", 32'(cpu_dout), 32'h5A);

    base = acc_idx.size();
    d0 = done_cnt;
    start_dma(3'd3);
    wait_done(1'b0, n);
    chk("restart_len", 32'(n), 32'd513);
    tick();
    chk("restart_done_count", 32'(done_cnt - d0), 32'd1);
    if (acc_idx.size() > base)
      chk("restart_first_idx", 32'(acc_idx[base]), 32'h0);
    check_stream("restart", base, 3'd3);

    // Full read-back sweep through random mirrors
    for (int i = 0; i < 2048; i++)
      cpu_rd(13'(i) | 13'($urandom_range(0, 3) << 11));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
